mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single mem_controller command interface between the instruction-fetch unit (IF_) and the load/store unit (D_).
- Sequences one access at a time: arbitrate, latch, issue a one-cycle Execute, wait for DataReady, route the result back to the owner.
- Sits between the core pipeline and mem_controller; the CTL_ side connects port-for-port to mem_controller's requester side.
- Adds round-robin fairness and a completion timeout.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, owner IDs, error word.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; under contention the port that did not own the last access wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic       grant_valid,
    output owner_e     owner
);

    always_comb begin
        grant_valid = |req;
        owner       = OWN_IF;
        if (req == 2'b11) begin
            owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (req[1]) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_controller command port between instruction fetch and load/store, one access at a time.
// Grant one cycle after the request is seen, Execute the cycle after that, Valid one cycle after DataReady.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    output logic        IF_Grant,
    output logic [31:0] IF_Data,
    output logic        IF_Valid,
    input  logic        D_Req,
    input  logic        D_We,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_InData,
    input  logic [1:0]  D_ByteEn,
    input  logic        D_SignExtend,
    output logic        D_Grant,
    output logic [31:0] D_OutData,
    output logic        D_Valid,
    output logic        Err,
    input  logic        CTL_Ready,
    output logic        CTL_Execute,
    output logic        CTL_We,
    output logic [31:0] CTL_Address,
    output logic [31:0] CTL_InData,
    output logic [1:0]  CTL_ByteEn,
    output logic        CTL_SignExtend,
    input  logic [31:0] CTL_OutData,
    input  logic        CTL_DataReady
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    state_e        state, state_nxt;
    owner_e        owner_q, owner_nxt;
    owner_e        last_owner, last_owner_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          if_grant_nxt, d_grant_nxt, if_valid_nxt, d_valid_nxt, err_nxt, exec_nxt;
    logic [31:0]   if_data_nxt, d_data_nxt;
    logic          we_nxt, se_nxt;
    logic [31:0]   addr_nxt, indata_nxt;
    logic [1:0]    be_nxt;

    logic          arb_vld;
    owner_e        arb_owner;

    rr_arb2 u_rr (
        .req         ({D_Req, IF_Req}),
        .last_owner  (last_owner),
        .grant_valid (arb_vld),
        .owner       (arb_owner)
    );

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        if_grant_nxt   = 1'b0;
        d_grant_nxt    = 1'b0;
        if_valid_nxt   = 1'b0;
        d_valid_nxt    = 1'b0;
        err_nxt        = 1'b0;
        exec_nxt       = 1'b0;
        if_data_nxt    = IF_Data;
        d_data_nxt     = D_OutData;
        we_nxt         = CTL_We;
        se_nxt         = CTL_SignExtend;
        addr_nxt       = CTL_Address;
        indata_nxt     = CTL_InData;
        be_nxt         = CTL_ByteEn;

        case (state)
            IDLE: begin
                if (CTL_Ready && arb_vld) begin
                    owner_nxt = arb_owner;
                    state_nxt = ISSUE;
                    if (arb_owner == OWN_D) begin
                        d_grant_nxt = 1'b1;
                        we_nxt      = D_We;
                        addr_nxt    = D_Addr;
                        indata_nxt  = D_InData;
                        be_nxt      = D_ByteEn;
                        se_nxt      = D_SignExtend;
                    end else begin
                        // Fetches are always full-word reads; write data is left as-is.
                        if_grant_nxt = 1'b1;
                        we_nxt       = 1'b0;
                        addr_nxt     = IF_Addr;
                        be_nxt       = 2'b11;
                        se_nxt       = 1'b0;
                    end
                end
            end
            ISSUE: begin
                exec_nxt  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + CW'(1);
                if (CTL_DataReady) begin
                    if (owner_q == OWN_D) begin
                        d_data_nxt  = CTL_OutData;
                        d_valid_nxt = 1'b1;
                    end else begin
                        if_data_nxt  = CTL_OutData;
                        if_valid_nxt = 1'b1;
                    end
                    last_owner_nxt = owner_q;
                    state_nxt      = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt == LIMIT) begin
                    if (owner_q == OWN_D) begin
                        d_data_nxt  = ERR_DATA;
                        d_valid_nxt = 1'b1;
                    end else begin
                        if_data_nxt  = ERR_DATA;
                        if_valid_nxt = 1'b1;
                    end
                    err_nxt        = 1'b1;
                    last_owner_nxt = owner_q;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            owner_q        <= OWN_IF;
            last_owner     <= OWN_IF;
            cnt            <= '0;
            IF_Grant       <= 1'b0;
            D_Grant        <= 1'b0;
            IF_Valid       <= 1'b0;
            D_Valid        <= 1'b0;
            Err            <= 1'b0;
            IF_Data        <= '0;
            D_OutData      <= '0;
            CTL_Execute    <= 1'b0;
            CTL_We         <= 1'b0;
            CTL_Address    <= '0;
            CTL_InData     <= '0;
            CTL_ByteEn     <= 2'b11;
            CTL_SignExtend <= 1'b0;
        end else begin
            state          <= state_nxt;
            owner_q        <= owner_nxt;
            last_owner     <= last_owner_nxt;
            cnt            <= cnt_nxt;
            IF_Grant       <= if_grant_nxt;
            D_Grant        <= d_grant_nxt;
            IF_Valid       <= if_valid_nxt;
            D_Valid        <= d_valid_nxt;
            Err            <= err_nxt;
            IF_Data        <= if_data_nxt;
            D_OutData      <= d_data_nxt;
            CTL_Execute    <= exec_nxt;
            CTL_We         <= we_nxt;
            CTL_Address    <= addr_nxt;
            CTL_InData     <= indata_nxt;
            CTL_ByteEn     <= be_nxt;
            CTL_SignExtend <= se_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-script table plus hand sequences for contention, store, timeout, reset.
module tb_mem_arbiter;

    logic        Clk, Reset;
    logic        IF_Req, IF_Grant, IF_Valid;
    logic [31:0] IF_Addr, IF_Data;
    logic        D_Req, D_We, D_SignExtend, D_Grant, D_Valid, Err;
    logic [31:0] D_Addr, D_InData, D_OutData;
    logic [1:0]  D_ByteEn;
    logic        CTL_Ready, CTL_Execute, CTL_We, CTL_SignExtend, CTL_DataReady;
    logic [31:0] CTL_Address, CTL_InData, CTL_OutData;
    logic [1:0]  CTL_ByteEn;

    mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .Clk(Clk), .Reset(Reset),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Grant(IF_Grant), .IF_Data(IF_Data), .IF_Valid(IF_Valid),
        .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_InData(D_InData), .D_ByteEn(D_ByteEn),
        .D_SignExtend(D_SignExtend), .D_Grant(D_Grant), .D_OutData(D_OutData), .D_Valid(D_Valid),
        .Err(Err), .CTL_Ready(CTL_Ready), .CTL_Execute(CTL_Execute), .CTL_We(CTL_We),
        .CTL_Address(CTL_Address), .CTL_InData(CTL_InData), .CTL_ByteEn(CTL_ByteEn),
        .CTL_SignExtend(CTL_SignExtend), .CTL_OutData(CTL_OutData), .CTL_DataReady(CTL_DataReady)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // {IF_Grant, D_Grant, CTL_Execute, IF_Valid, D_Valid, Err}
    logic [5:0] flags;
    assign flags = {IF_Grant, D_Grant, CTL_Execute, IF_Valid, D_Valid, Err};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic        if_req, d_req, rdy, dr;
        logic [31:0] odata;
        logic [5:0]  fl;
        logic [31:0] if_data, d_data, addr;
    } vec_t;

    function automatic vec_t v(input logic ir, dq, rd, dr, input logic [31:0] od,
                               input logic [5:0] fl, input logic [31:0] ifd, dd, ad);
        vec_t r;
        r.if_req = ir; r.d_req = dq; r.rdy = rd; r.dr = dr; r.odata = od;
        r.fl = fl; r.if_data = ifd; r.d_data = dd; r.addr = ad;
        return r;
    endfunction

    vec_t tbl[16];

    initial begin
        logic [1:0] gexp;
        logic [31:0] aexp;

        Reset = 1'b1;
        IF_Req = 0; IF_Addr = 32'h200;
        D_Req = 0; D_We = 0; D_Addr = 32'h300; D_InData = 0; D_ByteEn = 2'b11; D_SignExtend = 0;
        CTL_Ready = 1; CTL_OutData = 0; CTL_DataReady = 0;
        #12;
        chk("reset_flags", flags, 6'b0);
        chk("reset_data", {IF_Data, D_OutData}, 64'h0);
        chk("reset_ctl", {CTL_We, CTL_Address, CTL_InData, CTL_ByteEn, CTL_SignExtend}, {1'b0, 32'h0, 32'h0, 2'b11, 1'b0});
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Contention: both held high, expected order D, IF, D, IF.
        IF_Req = 1; D_Req = 1;
        for (int k = 0; k < 4; k++) begin
            gexp = (k % 2 == 0) ? 2'b01 : 2'b10;
            aexp = (k % 2 == 0) ? 32'h300 : 32'h200;
            step();
            chk($sformatf("cont_grant%0d", k), {IF_Grant, D_Grant}, gexp);
            step();
            chk($sformatf("cont_exec%0d", k), {CTL_Execute, CTL_Address}, {1'b1, aexp});
            CTL_DataReady = 1; CTL_OutData = 32'hA000 + k;
            step();
            CTL_DataReady = 0;
            chk($sformatf("cont_valid%0d", k), {IF_Valid, D_Valid}, gexp);
            if (k % 2 == 0) chk($sformatf("cont_ddata%0d", k), D_OutData, 32'hA000 + k);
            else            chk($sformatf("cont_idata%0d", k), IF_Data, 32'hA000 + k);
        end
        IF_Req = 0; D_Req = 0;
        D_Addr = 32'h100;
        step();

        // Single load, stray DataReady in IDLE, backpressure on a fetch.
        tbl[0]  = v(0,1,1,0, 32'h0,        6'b010000, 32'hA003, 32'hA002,     32'h100);
        tbl[1]  = v(0,1,1,0, 32'h0,        6'b001000, 32'hA003, 32'hA002,     32'h100);
        tbl[2]  = v(0,1,1,0, 32'h0,        6'b000000, 32'hA003, 32'hA002,     32'h100);
        tbl[3]  = v(0,1,1,0, 32'h0,        6'b000000, 32'hA003, 32'hA002,     32'h100);
        tbl[4]  = v(0,1,1,1, 32'h12345678, 6'b000010, 32'hA003, 32'h12345678, 32'h100);
        tbl[5]  = v(0,0,1,0, 32'h0,        6'b000000, 32'hA003, 32'h12345678, 32'h100);
        tbl[6]  = v(0,0,1,1, 32'h00000BAD, 6'b000000, 32'hA003, 32'h12345678, 32'h100);
        for (int i = 7; i < 12; i++)
            tbl[i] = v(1,0,0,0, 32'h0,     6'b000000, 32'hA003, 32'h12345678, 32'h100);
        tbl[12] = v(1,0,1,0, 32'h0,        6'b100000, 32'hA003, 32'h12345678, 32'h200);
        tbl[13] = v(1,0,1,0, 32'h0,        6'b001000, 32'hA003, 32'h12345678, 32'h200);
        tbl[14] = v(1,0,1,1, 32'h5555,     6'b000100, 32'h5555, 32'h12345678, 32'h200);
        tbl[15] = v(0,0,1,0, 32'h0,        6'b000000, 32'h5555, 32'h12345678, 32'h200);
        for (int i = 0; i < 16; i++) begin
            IF_Req = tbl[i].if_req; D_Req = tbl[i].d_req; CTL_Ready = tbl[i].rdy;
            CTL_DataReady = tbl[i].dr; CTL_OutData = tbl[i].odata;
            step();
            chk($sformatf("tbl%0d", i), {flags, IF_Data, D_OutData, CTL_Address},
                {tbl[i].fl, tbl[i].if_data, tbl[i].d_data, tbl[i].addr});
        end
        CTL_DataReady = 0; CTL_Ready = 1;

        // Store pass-through.
        D_We = 1; D_InData = 32'hCAFEF00D; D_ByteEn = 2'b01; D_SignExtend = 1; D_Addr = 32'h400; D_Req = 1;
        step();
        chk("st_grant", flags, 6'b010000);
        step();
        chk("st_exec", {CTL_Execute, CTL_We, CTL_Address, CTL_InData, CTL_ByteEn, CTL_SignExtend},
            {1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 2'b01, 1'b1});
        CTL_DataReady = 1;
        step();
        CTL_DataReady = 0; D_Req = 0; D_We = 0;
        chk("st_valid", flags, 6'b000010);
        step();
        chk("st_hold", {CTL_Execute, CTL_We, CTL_Address, CTL_ByteEn}, {1'b0, 1'b1, 32'h400, 2'b01});

        // Timeout on a fetch: Valid+Err after the 4th WAIT cycle.
        IF_Addr = 32'h500; IF_Req = 1;
        step();
        chk("to_grant", flags, 6'b100000);
        step();
        chk("to_exec", {CTL_Execute, CTL_Address, CTL_ByteEn, CTL_We}, {1'b1, 32'h500, 2'b11, 1'b0});
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("to_wait%0d", i), flags, 6'b000000);
        end
        step();
        IF_Req = 0;
        chk("to_valid", {flags, IF_Data}, {6'b000101, 32'hDEADBEEF});
        CTL_DataReady = 1; CTL_OutData = 32'h11111111;
        step();
        CTL_DataReady = 0;
        chk("to_late_dr", {flags, IF_Data}, {6'b000000, 32'hDEADBEEF});

        // Back in IDLE: a new data access is granted, then reset lands in WAIT.
        D_Addr = 32'h600; D_Req = 1;
        step();
        chk("rst_grant", flags, 6'b010000);
        step();
        chk("rst_exec", CTL_Execute, 1'b1);
        #1;
        Reset = 1; D_Req = 0;
        #1;
        chk("rst_async_out", {flags, IF_Data, D_OutData, CTL_We, CTL_Address, CTL_InData, CTL_ByteEn, CTL_SignExtend},
            {6'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0});
        step();
        Reset = 0;
        CTL_DataReady = 1; CTL_OutData = 32'h22222222;
        step();
        CTL_DataReady = 0;
        chk("rst_dr_ignored", {flags, D_OutData}, {6'b0, 32'h0});
        step();
        chk("rst_idle_quiet", flags, 6'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
